arb_req_queue: RTL and testbench

- Front-end stage directly upstream of the round-robin arbiter.
- Holds one small FIFO per requester channel and drives the arbiter's N-bit req vector; req[i] is high while channel i holds data.
- Consumes the arbiter's registered one-hot grant, pops the granted channel, and presents that word on a shared output with its channel index.
- The shared output has no backpressure, because the arbiter has no ready input.

---
 rtl/arb_req_queue_if.sv | 51 +++++
 rtl/arb_req_queue.sv | 146 ++++++++++++++
 tb/tb_arb_req_queue.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_req_queue_if.sv
// ---------------------------------------------------------------------------
// arb_req_queue_if
// Bundles the request-queue side of the round-robin arbiter front end.
//   in_valid  [N]     per-channel push valid
//   in_ready  [N]     per-channel push ready
//   in_data   [N*DW]  channel i occupies bits [i*DW +: DW]
//   req       [N]     request vector towards the arbiter
//   grant     [N]     registered grant from the arbiter
//   out_valid         one-cycle pulse, served word valid
//   out_data  [DW]    served word
//   out_id    [IW]    index of the served channel
//   err               sticky grant error (only with ARBQ_GRANT_CHECK_EN)
// Modports: slave = the queue block, master = the driving/observing side.
// Optional macro: ARBQ_GRANT_CHECK_EN adds the err signal.
// ---------------------------------------------------------------------------
interface arb_req_queue_if #(
  parameter int N  = 3,
  parameter int DW = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
`ifdef ARBQ_GRANT_CHECK_EN
  logic            err;

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, out_valid, out_data, out_id, err
  );
  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, out_valid, out_data, out_id, err
  );
`else
  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, out_valid, out_data, out_id
  );
  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, out_valid, out_data, out_id
  );
`endif
endinterface

// File: rtl/arb_req_queue.sv
// ---------------------------------------------------------------------------
// arb_req_queue
// Front-end stage directly upstream of the round-robin arbiter. Holds one
// small FIFO per requester channel, raises req[i] while channel i holds data,
// pops the channel selected by the arbiter's registered grant and presents
// the popped word on a shared registered output together with its index.
// The shared output has no backpressure.
// Ports:
//   clk     rising-edge clock
//   rst_an  asynchronous active-low reset (FIFO storage is not reset)
//   bus     arb_req_queue_if.slave (push side, req/grant, served output)
// Parameters: N channels, DW data width, DEPTH entries per channel
// (power of two, >= 2). IW = $clog2(N) is derived.
// Optional macro: ARBQ_GRANT_CHECK_EN enables the sticky err output that
// flags multi-bit grants and grants to empty channels.
// ---------------------------------------------------------------------------
module arb_req_queue #(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_an,
  arb_req_queue_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem_q   [N][DEPTH];
  logic [PW-1:0] wrPtr_q [N];
  logic [PW-1:0] wrPtr_d [N];
  logic [PW-1:0] rdPtr_q [N];
  logic [PW-1:0] rdPtr_d [N];
  logic [CW-1:0] count_q [N];
  logic [CW-1:0] count_d [N];

  logic          outValid_q, outValid_d;
  logic [DW-1:0] outData_q, outData_d;
  logic [IW-1:0] outId_q, outId_d;

  logic [N-1:0]  readyVec;
  logic [N-1:0]  reqVec;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic          selValid;
  logic [IW-1:0] selIdx;
  logic          popEn;

  // Status flags come only from registered counts, so in_ready never
  // depends on grant and a full channel stays not-ready even while popping.
  always_comb begin
    readyVec = '0;
    reqVec   = '0;
    for (int i = 0; i < N; i++) begin
      readyVec[i] = (count_q[i] != FULL);
      reqVec[i]   = (count_q[i] != '0);
    end
  end

  // Lowest-index set grant bit wins; extra bits never cause a pop.
  always_comb begin
    selValid = 1'b0;
    selIdx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.grant[i]) begin
        selValid = 1'b1;
        selIdx   = IW'(i);
      end
    end
  end

  assign popEn = selValid && (count_q[selIdx] != '0);
  assign push  = bus.in_valid & readyVec;
  assign pop   = popEn ? (N'(1) << selIdx) : '0;

  // Pointer/count next state plus the served-word register contents.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wrPtr_d[i] = wrPtr_q[i];
      rdPtr_d[i] = rdPtr_q[i];
      count_d[i] = count_q[i];
      if (push[i]) wrPtr_d[i] = wrPtr_q[i] + 1'b1;
      if (pop[i])  rdPtr_d[i] = rdPtr_q[i] + 1'b1;
      if (push[i] && !pop[i])      count_d[i] = count_q[i] + 1'b1;
      else if (!push[i] && pop[i]) count_d[i] = count_q[i] - 1'b1;
    end
    outValid_d = popEn;
    outData_d  = outData_q;
    outId_d    = outId_q;
    if (popEn) begin
      outData_d = mem_q[selIdx][rdPtr_q[selIdx]];
      outId_d   = selIdx;
    end
  end

  // Storage has no reset; stale contents are unreachable once counts clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem_q[i][wrPtr_q[i]] <= bus.in_data[i*DW +: DW];
    end
  end

`ifdef ARBQ_GRANT_CHECK_EN
  logic err_q, err_d;
  logic multiGrant;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign multiGrant = (bus.grant & (bus.grant - 1'b1)) != '0;
  assign err_d      = err_q | multiGrant | (selValid && (count_q[selIdx] == '0));
  assign bus.err    = err_q;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      for (int i = 0; i < N; i++) begin
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
        count_q[i] <= '0;
      end
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outId_q    <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outId_q    <= outId_d;
    end
  end

  assign bus.in_ready  = readyVec;
  assign bus.req       = reqVec;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_id    = outId_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// ---------------------------------------------------------------------------
// tb_arb_req_queue
// Drives arb_req_queue through directed scenarios, optionally with a simple
// behavioural round-robin arbiter closing the req/grant loop. A queue-based
// model of the channels predicts req, in_ready and the served output on
// every cycle; directed literal expectations pin the model.
// Optional macro: ARBQ_GRANT_CHECK_EN (also checks err).
// ---------------------------------------------------------------------------
module tb_arb_req_queue;
  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic clk    = 1'b0;
  logic rst_an = 1'b0;

  arb_req_queue_if #(.N(N), .DW(DW)) bus();

  arb_req_queue #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_an(rst_an),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [N-1:0]    stimValid = '0;
  logic [N*DW-1:0] stimData  = '0;
  logic [N-1:0]    gntDirect = '0;
  logic [N-1:0]    arbGrant  = '0;
  logic            arbOn     = 1'b0;
  int              arbLast   = N - 1;

  assign bus.in_valid = stimValid;
  assign bus.in_data  = stimData;
  assign bus.grant    = arbOn ? arbGrant : gntDirect;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One stimulus cycle: inputs change on the falling edge.
  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*DW-1:0] data,
                               input logic [N-1:0] gnt);
    @(negedge clk);
    stimValid = valid;
    stimData  = data;
    gntDirect = gnt;
  endtask

  // Round-robin arbiter stand-in: registered one-hot grant, never the
  // channel it is granting right now, search starts after the last winner.
  function automatic logic [N-1:0] arbPick(input logic [N-1:0] cand, input int last);
    logic [N-1:0] g;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (g == '0 && cand[c]) g[c] = 1'b1;
    end
    return g;
  endfunction

  function automatic int oneHotIdx(input logic [N-1:0] g, input int last);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return last;
  endfunction

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      arbGrant <= '0;
      arbLast  <= N - 1;
    end else if (!arbOn) begin
      arbGrant <= '0;
    end else begin
      arbGrant <= arbPick(bus.req & ~arbGrant, arbLast);
      arbLast  <= oneHotIdx(arbPick(bus.req & ~arbGrant, arbLast), arbLast);
    end
  end

  // Behavioural model: one queue per channel.
  typedef logic [DW-1:0] byteQ_t [$];
  byteQ_t        mq [N];
  logic          expValid = 1'b0;
  logic [DW-1:0] expData  = '0;
  logic [IW-1:0] expId    = '0;
  logic          expErr   = 1'b0;

  task automatic modelReset();
    for (int i = 0; i < N; i++) mq[i].delete();
    expValid = 1'b0;
    expData  = '0;
    expId    = '0;
    expErr   = 1'b0;
  endtask

  task automatic modelStep();
    logic [N-1:0] acc;
    int sel;
    for (int i = 0; i < N; i++) acc[i] = bus.in_valid[i] && (mq[i].size() < DEPTH);
    sel = -1;
    for (int i = 0; i < N; i++) if (sel < 0 && bus.grant[i]) sel = i;
    expValid = 1'b0;
    if ($countones(bus.grant) > 1) expErr = 1'b1;
    if (sel >= 0) begin
      if (mq[sel].size() > 0) begin
        expValid = 1'b1;
        expData  = mq[sel].pop_front();
        expId    = IW'(sel);
      end else begin
        expErr = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(bus.in_data[i*DW +: DW]);
  endtask

  function automatic logic [N-1:0] modelReq();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  function automatic logic [N-1:0] modelReady();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() != DEPTH);
    return r;
  endfunction

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) modelReset();
    else         modelStep();
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_an) begin
      checkOutput("req", 32'(bus.req), 32'(modelReq()));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(modelReady()));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
      checkOutput("out_data", 32'(bus.out_data), 32'(expData));
      checkOutput("out_id", 32'(bus.out_id), 32'(expId));
`ifdef ARBQ_GRANT_CHECK_EN
      checkOutput("err", 32'(bus.err), 32'(expErr));
`endif
    end
  end

  // Log of served words for sequence checks.
  int logId   [$];
  int logData [$];
  always @(negedge clk) begin
    if (rst_an && bus.out_valid) begin
      logId.push_back(int'(bus.out_id));
      logData.push_back(int'(bus.out_data));
    end
  end

  logic [7:0] fillExp  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] fairData [6] = '{8'h01, 8'h11, 8'h21, 8'h02, 8'h12, 8'h22};
  int         fairId   [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    checkOutput("rst_req", 32'(bus.req), 32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h7);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("rst_out_id", 32'(bus.out_id), 32'h0);
    rst_an = 1'b1;

    // Single push with the arbiter attached: output 3 edges after push.
    arbOn = 1'b1;
    applyStimulus(3'b100, {8'hA5, 8'h00, 8'h00}, 3'b000);
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(3'b000, '0, 3'b000);
      if (k == 1) checkOutput("push_req", 32'(bus.req), 32'h4);
      if (bus.out_valid && seen == 0) begin
        seen = k;
        checkOutput("push_data", 32'(bus.out_data), 32'hA5);
        checkOutput("push_id", 32'(bus.out_id), 32'h2);
      end
    end
    checkOutput("push_latency", 32'(seen), 32'd3);
    arbOn = 1'b0;

    // Fill channel 0, overflow attempt, then drain with single grant pulses.
    logId.delete();
    logData.delete();
    for (int w = 0; w < 4; w++) applyStimulus(3'b001, {16'h0, fillExp[w]}, 3'b000);
    applyStimulus(3'b001, {16'h0, 8'h55}, 3'b000);
    checkOutput("fill_full", 32'(bus.in_ready[0]), 32'h0);
    applyStimulus(3'b000, '0, 3'b000);
    checkOutput("fill_reject", 32'(bus.in_ready[0]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b000, '0, 3'b001);
      applyStimulus(3'b000, '0, 3'b000);
      if (k == 0) checkOutput("fill_ready_back", 32'(bus.in_ready[0]), 32'h1);
    end
    repeat (3) applyStimulus(3'b000, '0, 3'b000);
    checkOutput("fill_count", 32'(logData.size()), 32'd4);
    for (int k = 0; k < 4 && k < logData.size(); k++) begin
      checkOutput("fill_order", 32'(logData[k]), 32'(fillExp[k]));
      checkOutput("fill_id", 32'(logId[k]), 32'd0);
    end
    checkOutput("fill_empty", 32'(bus.req), 32'h0);

    // Fairness: two words on every channel, arbiter rotates through them.
    logId.delete();
    logData.delete();
    arbOn = 1'b1;
    applyStimulus(3'b111, {8'h21, 8'h11, 8'h01}, 3'b000);
    applyStimulus(3'b111, {8'h22, 8'h12, 8'h02}, 3'b000);
    repeat (14) applyStimulus(3'b000, '0, 3'b000);
    checkOutput("fair_count", 32'(logData.size()), 32'd6);
    for (int k = 0; k < 6 && k < logData.size(); k++) begin
      checkOutput("fair_data", 32'(logData[k]), 32'(fairData[k]));
      checkOutput("fair_id", 32'(logId[k]), 32'(fairId[k]));
      if (k > 0) checkOutput("fair_norepeat", 32'(logId[k] != logId[k-1]), 32'h1);
    end
    arbOn = 1'b0;

    // Simultaneous push and pop on channel 1.
    applyStimulus(3'b010, {8'h00, 8'h77, 8'h00}, 3'b000);
    applyStimulus(3'b010, {8'h00, 8'h5A, 8'h00}, 3'b010);
    applyStimulus(3'b000, '0, 3'b000);
    checkOutput("pp_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("pp_old_head", 32'(bus.out_data), 32'h77);
    checkOutput("pp_id", 32'(bus.out_id), 32'h1);
    checkOutput("pp_req", 32'(bus.req), 32'h2);
    applyStimulus(3'b000, '0, 3'b010);
    applyStimulus(3'b000, '0, 3'b000);
    checkOutput("pp_new_word", 32'(bus.out_data), 32'h5A);
    checkOutput("pp_drained", 32'(bus.req), 32'h0);

    // Grant to an empty channel: no output.
    applyStimulus(3'b000, '0, 3'b100);
    applyStimulus(3'b000, '0, 3'b000);
    checkOutput("empty_no_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("empty_hold", 32'(bus.out_data), 32'h5A);
`ifdef ARBQ_GRANT_CHECK_EN
    checkOutput("empty_err", 32'(bus.err), 32'h1);
    @(negedge clk);
    rst_an = 1'b0;
    @(negedge clk);
    rst_an = 1'b1;
    checkOutput("err_cleared", 32'(bus.err), 32'h0);
`endif

    // Multi-bit grant: only the lowest channel pops.
    applyStimulus(3'b011, {8'h00, 8'hBB, 8'hAA}, 3'b000);
    applyStimulus(3'b000, '0, 3'b011);
    applyStimulus(3'b000, '0, 3'b000);
    checkOutput("multi_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("multi_id", 32'(bus.out_id), 32'h0);
    checkOutput("multi_data", 32'(bus.out_data), 32'hAA);
    checkOutput("multi_req", 32'(bus.req), 32'h2);
`ifdef ARBQ_GRANT_CHECK_EN
    checkOutput("multi_err", 32'(bus.err), 32'h1);
`endif
    applyStimulus(3'b000, '0, 3'b010);
    applyStimulus(3'b000, '0, 3'b000);
    checkOutput("multi_ch1", 32'(bus.out_data), 32'hBB);
`ifdef ARBQ_GRANT_CHECK_EN
    checkOutput("multi_err_sticky", 32'(bus.err), 32'h1);
`endif

    // Reset mid-traffic with channel 1 holding two words.
    applyStimulus(3'b010, {8'h00, 8'hC1, 8'h00}, 3'b000);
    applyStimulus(3'b010, {8'h00, 8'hC2, 8'h00}, 3'b000);
    applyStimulus(3'b010, {8'h00, 8'hC3, 8'h00}, 3'b000);
    applyStimulus(3'b000, '0, 3'b010);
    applyStimulus(3'b000, '0, 3'b000);
    checkOutput("mid_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("mid_req", 32'(bus.req), 32'h2);
    #2 rst_an = 1'b0;
    #1;
    checkOutput("async_req", 32'(bus.req), 32'h0);
    checkOutput("async_in_ready", 32'(bus.in_ready), 32'h7);
    checkOutput("async_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("async_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("async_out_id", 32'(bus.out_id), 32'h0);
    repeat (2) @(negedge clk);
    rst_an = 1'b1;
    logId.delete();
    logData.delete();
    arbOn = 1'b1;
    repeat (8) applyStimulus(3'b000, '0, 3'b000);
    checkOutput("no_stale", 32'(logData.size()), 32'd0);
    arbOn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
